// File: rtl/alu_pkg.sv
// Shared ALU definitions: RV32M funct3 codes, ALU result-mux select codes,
// multiply/divide FSM states and small operand helpers.
package alu_pkg;

    // RV32M funct3 encodings
    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    // ALU result mux select codes
    localparam logic [2:0] ALU_SEL_ADD    = 3'b000;
    localparam logic [2:0] ALU_SEL_SUB    = 3'b001;
    localparam logic [2:0] ALU_SEL_AND    = 3'b010;
    localparam logic [2:0] ALU_SEL_OR     = 3'b011;
    localparam logic [2:0] ALU_SEL_XOR    = 3'b100;
    localparam logic [2:0] ALU_SEL_SLT    = 3'b101;
    localparam logic [2:0] ALU_SEL_SHIFT  = 3'b110;
    localparam logic [2:0] ALU_SEL_MULDIV = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } md_state_e;

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM
    function automatic logic op_signed_a(input logic [2:0] f);
        return (f == MULDIV_MULH) || (f == MULDIV_MULHSU) ||
               (f == MULDIV_DIV)  || (f == MULDIV_REM);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM
    function automatic logic op_signed_b(input logic [2:0] f);
        return (f == MULDIV_MULH) || (f == MULDIV_DIV) || (f == MULDIV_REM);
    endfunction

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative multiplier/divider on a 64-bit accumulator.
// Multiply: acc = {partial_hi, multiplier}; add-then-shift-right.
// Divide (only with ALU_MULDIV_DIV_EN): acc = {remainder, dividend/quotient};
// restoring shift-left-then-subtract.
module muldiv_step (
    input  logic        is_div,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next
);

    logic [32:0] mul_sum;
`ifdef ALU_MULDIV_DIV_EN
    logic [32:0] rem_sh;
    logic [32:0] diff;
`else
    logic unused_is_div;
    assign unused_is_div = is_div;
`endif

    // Select add-shift or subtract-shift for this iteration
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        acc_next = {mul_sum, acc[31:1]};
`ifdef ALU_MULDIV_DIV_EN
        // Shifted remainder may carry into bit 32; then it always exceeds the divisor.
        rem_sh = acc[63:31];
        diff   = rem_sh - {1'b0, operand};
        if (is_div) begin
            if (!diff[32]) begin
                acc_next = {diff[31:0], acc[30:0], 1'b1};
            end else begin
                acc_next = {rem_sh[31:0], acc[30:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Iterative RV32M multiply/divide unit feeding ALU select ALU_SEL_MULDIV.
// Start/busy/done handshake, 32 iterations, result held until the next op.
// Build option: ALU_MULDIV_DIV_EN enables the divider; without it divide ops
// complete through FIX with result 0.
module alu_muldiv_unit
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        kill,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    md_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [63:0] acc_q, acc_d, acc_step;
    logic [31:0] opb_q, opb_d;
    logic        neg_res_q, neg_res_d;
`ifdef ALU_MULDIV_DIV_EN
    logic        neg_rem_q, neg_rem_d;
    logic        div_zero_q, div_zero_d;
    logic [31:0] quo, rem;
`endif
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;

    logic        a_sign, b_sign;
    logic [31:0] a_mag, b_mag;
    logic [63:0] prod;
    logic [31:0] fix_result;

    muldiv_step u_step (
        .is_div   (op_q[2]),
        .acc      (acc_q),
        .operand  (opb_q),
        .acc_next (acc_step)
    );

    // Operand signs and magnitudes for an op presented at start
    always_comb begin
        a_sign = op_signed_a(funct3) & rs1[31];
        b_sign = op_signed_b(funct3) & rs2[31];
        a_mag  = cond_neg32(rs1, a_sign);
        b_mag  = cond_neg32(rs2, b_sign);
    end

    // Sign correction and result selection applied in FIX
    always_comb begin
        prod       = neg_res_q ? (~acc_q + 64'd1) : acc_q;
        fix_result = (op_q == MULDIV_MUL) ? prod[31:0] : prod[63:32];
`ifdef ALU_MULDIV_DIV_EN
        // Signed overflow (0x80000000 / -1) falls out of the magnitude path naturally.
        quo = cond_neg32(acc_q[31:0], neg_res_q);
        rem = cond_neg32(acc_q[63:32], neg_rem_q);
        if (div_zero_q) begin
            quo = 32'hFFFF_FFFF;
        end
        if (op_q[2]) begin
            fix_result = op_q[1] ? rem : quo;
        end
`else
        if (op_q[2]) begin
            fix_result = 32'd0;
        end
`endif
    end

    // FSM next-state, iteration and output updates
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        neg_res_d  = neg_res_q;
`ifdef ALU_MULDIV_DIV_EN
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
`endif
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        unique case (state_q)
            StIdle: begin
                if (!kill && start) begin
                    op_d      = funct3;
                    acc_d     = {32'd0, a_mag};
                    opb_d     = b_mag;
                    neg_res_d = a_sign ^ b_sign;
                    cnt_d     = 5'd31;
                    busy_d    = 1'b1;
`ifdef ALU_MULDIV_DIV_EN
                    neg_rem_d  = a_sign;
                    div_zero_d = (rs2 == 32'd0);
                    state_d    = StCalc;
`else
                    state_d    = funct3[2] ? StFix : StCalc;
`endif
                end
            end
            StCalc: begin
                if (kill) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                if (!kill) begin
                    result_d = fix_result;
                    done_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 5'd0;
            op_q       <= 3'd0;
            acc_q      <= 64'd0;
            opb_q      <= 32'd0;
            neg_res_q  <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
`endif
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            neg_res_q  <= neg_res_d;
`ifdef ALU_MULDIV_DIV_EN
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
`endif
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit: arithmetic reference model plus
// directed vectors with hand-computed results and latencies.
module tb_alu_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_total = 0;
    int n_pass  = 0;
    logic chk_en = 1'b0;

`ifdef ALU_MULDIV_DIV_EN
    localparam int DivLat = 33;
`else
    localparam int DivLat = 1;
`endif
    localparam int MulLat = 33;

    alu_muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .kill   (kill),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural RV32M result, from plain integer arithmetic
    function automatic logic [31:0] model_op(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 64'd0;
        case (f)
            3'b000: begin p = sa * sb; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
`ifdef ALU_MULDIV_DIV_EN
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
`else
            default: return 32'd0;
`endif
        endcase
    endfunction

    // Transaction-level model: accepted op completes a fixed number of edges later
    logic        m_busy, m_done;
    logic [31:0] m_result, m_pend;
    int          m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_result = 32'd0;
            m_pend   = 32'd0;
            m_left   = 0;
        end else begin
            m_done = 1'b0;
            if (m_left != 0) begin
                if (kill) begin
                    m_left = 0;
                    m_busy = 1'b0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_done   = 1'b1;
                        m_busy   = 1'b0;
                        m_result = m_pend;
                    end
                end
            end else if (start && !kill) begin
                m_pend = model_op(funct3, rs1, rs2);
                m_left = funct3[2] ? DivLat : MulLat;
                m_busy = 1'b1;
            end
        end
    end

    // Compare DUT outputs with the model every cycle, away from the clock edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", {31'd0, busy}, {31'd0, m_busy});
            check("model_done", {31'd0, done}, {31'd0, m_done});
            check("model_result", result, m_result);
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3 = f;
        rs1    = a;
        rs2    = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        rs1    = $urandom;
        rs2    = $urandom;
    endtask

    // Count edges until done, and busy cycles on the way
    task automatic wait_done(input string name, input int lat, input logic [31:0] exp);
        int n  = 0;
        int nb = 0;
        while (done !== 1'b1 && n < 80) begin
            if (busy === 1'b1) nb++;
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, n, lat);
        check({name, "_busy_cycles"}, nb, lat);
        check({name, "_result"}, result, exp);
    endtask

    initial begin
        rst_n  = 1'b1;
        start  = 1'b0;
        kill   = 1'b0;
        funct3 = 3'd0;
        rs1    = 32'd0;
        rs2    = 32'd0;
        #2;
        rst_n  = 1'b0;
        #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        wait_done("mul", MulLat, 32'hFFFF_FFEB);
        // Back-to-back: the done cycle is idle, so these starts are accepted immediately
        issue(3'b001, 32'h8000_0000, 32'h8000_0000);
        wait_done("mulh", MulLat, 32'h4000_0000);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mulhu", MulLat, 32'hFFFF_FFFE);
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mulhsu", MulLat, 32'hFFFF_FFFF);

`ifdef ALU_MULDIV_DIV_EN
        issue(3'b100, 32'd100, 32'd0);
        wait_done("div_by_zero", DivLat, 32'hFFFF_FFFF);
        issue(3'b110, 32'd100, 32'd0);
        wait_done("rem_by_zero", DivLat, 32'd100);
        issue(3'b100, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", DivLat, 32'hFFFF_FFFD);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2);
        wait_done("rem_neg", DivLat, 32'hFFFF_FFFF);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", DivLat, 32'h8000_0000);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("rem_ovf", DivLat, 32'd0);
        issue(3'b101, 32'd10, 32'd3);
        wait_done("divu", DivLat, 32'd3);
        issue(3'b111, 32'd10, 32'd3);
        wait_done("remu", DivLat, 32'd1);
`else
        issue(3'b101, 32'd10, 32'd3);
        wait_done("divu_disabled", DivLat, 32'd0);
        issue(3'b000, 32'd3, 32'd5);
        wait_done("mul_small", MulLat, 32'd15);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2);
        wait_done("rem_disabled", DivLat, 32'd0);
`endif

        // Start while busy is ignored; the original op completes on time
        issue(3'b000, 32'h0000_1234, 32'h0000_0010);
        repeat (9) @(posedge clk);
        #1;
        funct3 = 3'b011;
        rs1    = 32'hFFFF_FFFF;
        rs2    = 32'hFFFF_FFFF;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        wait_done("busy_ignore", MulLat - 10, 32'h0001_2340);

        // Kill mid-calculation: no done, result held, restart next cycle
        issue(3'b000, 32'd5, 32'd6);
        repeat (19) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_busy", {31'd0, busy}, 32'd0);
        check("kill_done", {31'd0, done}, 32'd0);
        check("kill_result", result, 32'h0001_2340);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("after_kill", MulLat, 32'hFFFF_FFFE);

        // Kill in idle wins over start
        funct3 = 3'b000;
        rs1    = 32'd2;
        rs2    = 32'd2;
        start  = 1'b1;
        kill   = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        kill   = 1'b0;
        check("idle_kill_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-operation
        issue(3'b000, 32'd9, 32'd9);
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_result", result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        wait_done("post_reset_mul", MulLat, 32'hFFFF_FFEB);

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_unit.md
# alu_muldiv_unit

Iterative RV32M multiply/divide unit producing the result for ALU select code 3'b111 (the reserved slot of the ALU result mux). It accepts one operation at a time via a start/busy/done handshake, computes over a fixed number of cycles, and holds the result stable for the mux until the next operation. The core stalls on `busy`.

## Interface
- No parameters; width fixed at 32 bits.
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Ports:
  - `clk  in  1` — clock; all state updates on rising edge.
  - `rst_n  in  1` — asynchronous active-low reset.
  - `start  in  1` — request; sampled only in IDLE.
  - `kill  in  1` — abort in-flight operation (pipeline flush).
  - `funct3  in  3` — RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - `rs1  in  32` — operand A / dividend.
  - `rs2  in  32` — operand B / divisor.
  - `busy  out  1` — high while an operation is in flight.
  - `done  out  1` — one-cycle pulse; result valid from this cycle.
  - `result  out  32` — registered result; held until the next accepted start.

## Operation
- States:
  - **IDLE**: `start`=1 latches `funct3`, operands and sign info; takes absolute values as the op requires; counter=31; goes to CALC.
  - **CALC**: 32 iterations, one per cycle.
    - Multiply: radix-2 shift-add on 64-bit product register.
    - Divide: restoring shift-subtract on 64-bit remainder/quotient register.
    - Counter decrements; at 0 goes to FIX.
  - **FIX**: applies sign correction; selects low/high product, quotient or remainder; writes `result`; pulses `done`; returns to IDLE.
- Signedness:
  - MULH: signed×signed.
  - MULHSU: signed rs1 × unsigned rs2.
  - DIV/REM: signed. Remainder takes the sign of the dividend.
- Boundary cases, handled in FIX with the same latency:
  - Divide by zero: quotient = 0xFFFFFFFF; remainder = rs1.
  - Overflow 0x80000000 / 0xFFFFFFFF (signed): quotient = 0x80000000; remainder = 0.
- `start` while `busy`: ignored; operand changes have no effect on the in-flight op.
- `kill` in CALC or FIX: next state IDLE; no `done`; `result` unchanged. `kill` in IDLE has priority over `start`, so the start is dropped.
- Reset mid-operation: immediate return to IDLE; all outputs return to reset values.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0; state IDLE; counter 0.
- Start sampled at edge E0:
  - `busy` goes high after E0.
  - CALC occupies E1–E32; FIX is entered after E32.
  - `result` is written at E33 and `done` is high for the cycle after E33.
  - `busy` drops after E33.
- Fixed latency: 34 cycles from start edge to done visible. Back-to-back start is accepted at E34 (the done cycle is IDLE).
- `busy` is registered. `done` is registered and never asserted two consecutive cycles.

## Configuration
- `ALU_MULDIV_DIV_EN`:
  - Defined: full RV32M as above.
  - Undefined: divider datapath omitted. Ops 100–111 are accepted, go directly to FIX, and produce `result`=0 with `done` visible 2 cycles after the start edge. Multiply ops are unchanged.

## Structure
- Shared package `alu_pkg`:
  - funct3 op constants (`MULDIV_MUL`…`MULDIV_REMU`).
  - ALU select codes, including `ALU_SEL_MULDIV` = 3'b111.
  - State enum (IDLE, CALC, FIX).
- One sub-module `muldiv_step`: combinational single iteration (add-shift or subtract-shift on the 64-bit accumulator), instantiated once.
- FSM, counter and sign fix-up stay in the top module.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD → `result`=0xFFFFFFEB; `done` visible exactly 34 cycles after start; `busy` high 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV rs1=100, rs2=0 → 0xFFFFFFFF; REM → 100; DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Start with new operands while busy at cycle 10 → ignored, original result delivered at cycle 34. `kill` at cycle 20 → no `done`, `result` retains previous value, new start accepted next cycle.
- `rst_n` low at cycle 15 → `busy`, `done`, `result` = 0 immediately. Without `ALU_MULDIV_DIV_EN`: DIVU 10/3 → `result`=0, `done` at cycle 2.
